// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch FSM states and the IF/ID payload.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
  } if_id_t;

  function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that absorbs a word acked during a stall.
// Build option FETCH_PERF_EN adds a counter of words loaded into IF/ID.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        stall,
  input  logic        flush,
  input  if_id_t      word,
  output logic        valid,
  output if_id_t      entry,
  output logic        valid_nxt_c,
  output logic        skid_nxt_c,
  output logic [31:0] fetch_count
);

  if_id_t entry_q, entry_d;
  if_id_t skid_q, skid_d;
  logic   valid_q, valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   hold;

  assign hold = valid_q && stall;

  // Flush beats everything; a held entry parks new data in the skid; otherwise skid drains first.
  always_comb begin
    entry_d      = entry_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (hold) begin
      if (load) begin
        skid_d       = word;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      entry_d      = skid_q;
      valid_d      = 1'b1;
      skid_valid_d = 1'b0;
    end else if (load) begin
      entry_d = word;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q      <= '{instr: NOP_INSTR, pc4: 32'h0};
      skid_q       <= '{instr: NOP_INSTR, pc4: 32'h0};
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign valid       = valid_q;
  assign entry       = entry_q;
  assign valid_nxt_c = valid_d;
  assign skid_nxt_c  = skid_valid_d;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        loaded;

  // A word counts once, when it lands in IF/ID (directly or out of the skid).
  assign loaded = !flush && !hold && (skid_valid_q || load);

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (loaded) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_count_q <= 32'h0;
    else     fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ack handshake, redirect/drain FSM, IF/ID fill.
// Build option FETCH_PERF_EN enables the fetch_count performance counter.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [5:0]        if_id_op,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;

  logic              ack_acc;
  logic              redirect;
  logic              pending;
  logic [ADDR_W-1:0] redirect_pc;
  logic              load_word;
  logic              flush;
  logic              valid_nxt_c;
  logic              skid_nxt_c;
  if_id_t            word;
  if_id_t            entry;

  assign ack_acc  = req_q && imem_ack;
  assign pending  = req_q && !imem_ack;
  assign redirect = jump || branch_taken;

  // Jump wins over branch; targets always land word-aligned.
  assign redirect_pc = jump ? ADDR_W'({if_id_pc4[ADDR_W-1 -: 4], jump_target, 2'b00})
                            : (branch_target & ~ADDR_W'(3));

  // Data-path controls for IF/ID; kept apart from next-state logic to avoid a feedback through the sub-module.
  always_comb begin
    load_word = 1'b0;
    flush     = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect)     flush     = 1'b1;
        else if (ack_acc) load_word = 1'b1;
      end
      DRAIN: begin
        if (redirect) flush = 1'b1;
      end
      default: flush = 1'b1;
    endcase
  end

  assign word = '{instr: imem_rdata, pc4: pc_q + ADDR_W'(4)};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d  = redirect_pc;
          req_d = 1'b1;
          if (pending) state_d = DRAIN;
          else         addr_d  = redirect_pc;
        end else if (pending) begin
          req_d = 1'b1;
        end else begin
          if (ack_acc) pc_d = pc_q + ADDR_W'(4);
          addr_d = pc_d;
          req_d  = !skid_nxt_c && !(valid_nxt_c && stall);
        end
      end
      DRAIN: begin
        // Old address stays on the bus until its ack; only the target pc moves.
        req_d = 1'b1;
        if (redirect) pc_d = redirect_pc;
        if (ack_acc) begin
          state_d = FETCH;
          addr_d  = pc_d;
        end
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load_word),
    .stall       (stall),
    .flush       (flush),
    .word        (word),
    .valid       (if_id_valid),
    .entry       (entry),
    .valid_nxt_c (valid_nxt_c),
    .skid_nxt_c  (skid_nxt_c),
    .fetch_count (fetch_count)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_id_instr = entry.instr;
  assign if_id_op    = op_of(entry.instr);
  assign if_id_pc4   = entry.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, branch, jump drain, async reset, priority.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [5:0]  if_id_op;
  logic [31:0] if_id_pc4;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_op      (if_id_op),
    .if_id_pc4     (if_id_pc4),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef FETCH_PERF_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 26'h0;
    tick(); tick();
    chk("rst_req",   32'(imem_req),    32'h0);
    chk("rst_addr",  imem_addr,        32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr,      32'h0);
    chk("rst_op",    32'(if_id_op),    32'h0);
    chk("rst_pc4",   if_id_pc4,        32'h0);
    chk("rst_cnt",   fetch_count,      exp_cnt(0));

    // Streaming lw words, ack every cycle
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C08_0004;
    tick();
    chk("s1_req",   32'(imem_req),    32'h1);
    chk("s1_addr0", imem_addr,        32'h0);
    chk("s1_valid", 32'(if_id_valid), 32'h0);
    tick();
    chk("s1_valid1", 32'(if_id_valid), 32'h1);
    chk("s1_op1",    32'(if_id_op),    32'(OP_LW));
    chk("s1_pc4_1",  if_id_pc4,        32'h4);
    chk("s1_addr4",  imem_addr,        32'h4);
    tick();
    chk("s1_pc4_2",  if_id_pc4,        32'h8);
    chk("s1_addr8",  imem_addr,        32'h8);
    tick();
    chk("s1_pc4_3",  if_id_pc4,        32'hC);
    chk("s1_addrC",  imem_addr,        32'hC);
    chk("s1_cnt",    fetch_count,      exp_cnt(3));

    // Stall for 3 cycles; ack on the first goes to the skid
    stall = 1'b1; imem_rdata = 32'h012A_4020;
    tick();
    chk("s2_req_skid", 32'(imem_req),    32'h0);
    chk("s2_hold_pc4", if_id_pc4,        32'hC);
    chk("s2_hold_op",  32'(if_id_op),    32'(OP_LW));
    chk("s2_valid",    32'(if_id_valid), 32'h1);
    imem_ack = 1'b0;
    tick(); tick();
    chk("s2_req_skid3", 32'(imem_req), 32'h0);
    chk("s2_hold_pc4b", if_id_pc4,     32'hC);
    stall = 1'b0;
    tick();
    chk("s2_skid_pc4",   if_id_pc4,     32'h10);
    chk("s2_skid_op",    32'(if_id_op), 32'(OP_RTYPE));
    chk("s2_skid_instr", if_id_instr,   32'h012A_4020);
    chk("s2_req_again",  32'(imem_req), 32'h1);
    chk("s2_addr",       imem_addr,     32'h10);
    chk("s2_cnt",        fetch_count,   exp_cnt(4));
    tick();
    chk("s2_bubble", 32'(if_id_valid), 32'h0);
    chk("s2_addr_b", imem_addr,        32'h10);

    // Branch in the ack cycle discards the word
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk("s3_valid", 32'(if_id_valid), 32'h0);
    chk("s3_addr",  imem_addr,        32'h40);
    chk("s3_req",   32'(imem_req),    32'h1);
    chk("s3_cnt",   fetch_count,      exp_cnt(4));
    branch_taken = 1'b0; imem_rdata = 32'h1000_FFFF;
    tick();
    chk("s3_valid1", 32'(if_id_valid), 32'h1);
    chk("s3_op",     32'(if_id_op),    32'(OP_BEQ));
    chk("s3_pc4",    if_id_pc4,        32'h44);
    chk("s3_cnt5",   fetch_count,      exp_cnt(5));

    // Jump while a request is outstanding: drain the old address first
    branch_taken = 1'b1; branch_target = 32'h1000_0004; imem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("s4_br_addr", imem_addr, 32'h1000_0004);
    branch_taken = 1'b0; imem_rdata = 32'h0800_0010;
    tick();
    chk("s4_j_op",  32'(if_id_op), 32'(OP_J));
    chk("s4_j_pc4", if_id_pc4,     32'h1000_0008);
    chk("s4_addr",  imem_addr,     32'h1000_0008);
    imem_ack = 1'b0; jump = 1'b1; jump_target = 26'h10;
    tick();
    chk("s4_flush",  32'(if_id_valid), 32'h0);
    chk("s4_hold_a", imem_addr,        32'h1000_0008);
    chk("s4_req",    32'(imem_req),    32'h1);
    jump = 1'b0;
    tick(); tick();
    chk("s4_drain_addr", imem_addr,        32'h1000_0008);
    chk("s4_drain_req",  32'(imem_req),    32'h1);
    chk("s4_drain_vld",  32'(if_id_valid), 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hBADC_0DE0;
    tick();
    chk("s4_new_addr", imem_addr,        32'h1000_0040);
    chk("s4_discard",  32'(if_id_valid), 32'h0);
    chk("s4_cnt",      fetch_count,      exp_cnt(6));
    imem_rdata = 32'h8C09_0008;
    tick();
    chk("s4_load_pc4", if_id_pc4,   32'h1000_0044);
    chk("s4_load_ins", if_id_instr, 32'h8C09_0008);
    chk("s4_cnt7",     fetch_count, exp_cnt(7));

    // Async reset mid-request
    imem_ack = 1'b0; stall = 1'b1;
    tick();
    chk("s5_pre_valid", 32'(if_id_valid), 32'h1);
    chk("s5_pre_req",   32'(imem_req),    32'h1);
    #2; rst = 1'b1; #1;
    chk("s5_req",   32'(imem_req),    32'h0);
    chk("s5_addr",  imem_addr,        32'h0);
    chk("s5_valid", 32'(if_id_valid), 32'h0);
    chk("s5_instr", if_id_instr,      32'h0);
    chk("s5_op",    32'(if_id_op),    32'h0);
    chk("s5_pc4",   if_id_pc4,        32'h0);
    chk("s5_cnt",   fetch_count,      exp_cnt(0));
    tick();
    rst = 1'b0; stall = 1'b0;
    tick();
    chk("s5_first_req",  32'(imem_req), 32'h1);
    chk("s5_first_addr", imem_addr,     32'h0);

    // Jump beats branch; redirects in DRAIN keep the last target, low bits forced to 0
    imem_ack = 1'b1; imem_rdata = 32'h8C08_0004;
    tick();
    chk("s6_pc4", if_id_pc4, 32'h4);
    jump = 1'b1; jump_target = 26'h3; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    chk("s6_prio_addr", imem_addr, 32'hC);
    jump = 1'b0; imem_ack = 1'b0; branch_target = 32'h200;
    tick();
    chk("s6_drain_a", imem_addr, 32'hC);
    branch_target = 32'h302;
    tick();
    chk("s6_drain_b", imem_addr, 32'hC);
    branch_taken = 1'b0; imem_ack = 1'b1;
    tick();
    chk("s6_last_wins", imem_addr,        32'h300);
    chk("s6_valid0",    32'(if_id_valid), 32'h0);
    tick();
    chk("s6_pc4_300", if_id_pc4,   32'h304);
    chk("s6_cnt",     fetch_count, exp_cnt(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
